// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// ---------------------------------------------------------------------------
// Decoupled instruction-fetch front end. It issues sequential word-aligned
// PCs to instruction memory, tags each request with its PC, and buffers the
// in-order responses in a small FIFO so decode can stall without losing
// fetched words. A redirect flushes the FIFO, restarts fetch at the new PC,
// and arms a drop counter that swallows the responses still in flight.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. valid never waits on ready, and the payload is held stable
// while valid is high and ready is low. The imem response channel has no
// ready; credit accounting guarantees that every response has a free slot.
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   imem_req_valid/ready/addr    fetch request to instruction memory
//   imem_resp_valid/data         in-order response words, latency >= 1
//   redirect_valid/pc            flush and restart fetch at redirect_pc
//   out_valid/ready/pc/instr     FIFO head toward the IF/ID register
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  // Architectural state
  logic [XLEN-1:0] r_fetch_pc;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [PW-1:0]   r_tag_rd;
  logic [PW-1:0]   r_tag_wr;

  // Storage (no reset needed; validity is tracked by the counters)
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [XLEN-1:0] r_fifo_instr [DEPTH];
  logic [XLEN-1:0] r_tag        [DEPTH];

  logic [CW:0]     w_occupancy;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_resp_drop;
  logic            w_push;
  logic            w_head_valid;
  logic            w_pop;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [XLEN-1:0] w_tag_head;
  logic            w_unused_pc_low;

  // The low redirect bits are architecturally ignored.
  assign w_unused_pc_low = ^redirect_pc[1:0];

  // Credit check: FIFO entries plus in-flight requests never exceed DEPTH,
  // so every response lands in a free slot.
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid = ~reset & ~redirect_valid & (w_occupancy < DEPTH_W);
  assign w_req_fire  = w_req_valid & imem_req_ready;

  // Stale responses (from before a redirect) are swallowed; a response that
  // coincides with the redirect itself is always stale.
  assign w_resp_drop = (r_drop_cnt != '0) | redirect_valid;
  assign w_push      = imem_resp_valid & ~w_resp_drop;
  assign w_tag_head  = r_tag[r_tag_rd];

  assign w_head_valid = (r_count != '0);
  assign w_pop        = w_head_valid & out_ready;

  assign w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = reset ? RESET_PC : r_fetch_pc;
  assign out_valid      = ~reset & w_head_valid;
  assign out_pc         = out_valid ? r_fifo_pc[r_rd_ptr]    : '0;
  assign out_instr      = out_valid ? r_fifo_instr[r_rd_ptr] : '0;

  // Control state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      // The tag queue survives redirects so stale responses keep popping
      // tags in request order.
      if (w_req_fire)      r_tag_wr <= r_tag_wr + PW'(1);
      if (imem_resp_valid) r_tag_rd <= r_tag_rd + PW'(1);

      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_drop_cnt <= w_outstanding_nxt;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push)     r_wr_ptr   <= r_wr_ptr + PW'(1);
        if (w_pop)      r_rd_ptr   <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
        if (imem_resp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  // Tag and FIFO storage writes
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_req_fire) r_tag[r_tag_wr] <= r_fetch_pc;
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= w_tag_head;
        r_fifo_instr[r_wr_ptr] <= imem_resp_data;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(w_push && (r_count == DEPTH_C)));
  a_resp_has_tag: assert property (@(posedge clock) disable iff (reset)
    !(imem_resp_valid && (r_outstanding == '0)));
`endif

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Decoupled instruction-fetch front end for the 5-stage RISCVCPU pipeline. Sits upstream of the IF/ID register and downstream of the instruction memory.
- Generates sequential PCs and issues requests to imem. Buffers in-order responses in a small FIFO so the decode side can stall without losing fetched words.
- Handles redirects from branches and jumps by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- XLEN, 32, width of PC and instruction words.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first PC fetched after reset.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  imem accepts the request this cycle.
- imem_req_addr  output  XLEN  byte address of the request; always word-aligned.
- imem_resp_valid  input  1  response word valid; responses arrive in request order, latency ≥1 cycle.
- imem_resp_data  input  XLEN  instruction word.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  XLEN  new fetch PC; bits [1:0] are ignored and forced to 0.
- out_valid  output  1  FIFO head is valid toward IF/ID.
- out_ready  input  1  IF/ID consumes the head this cycle (deasserted on stall).
- out_pc  output  XLEN  PC of the head instruction.
- out_instr  output  XLEN  head instruction word.

Behaviour:
- Reset state: fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
- Output values while in reset: imem_req_valid=0, out_valid=0, imem_req_addr=RESET_PC, out_pc=0, out_instr=0.
- Issue rule: imem_req_valid=1 iff not reset, redirect_valid=0, and (fifo_count + outstanding) < DEPTH. Credit-based, so a response always finds a free slot.
- On request handshake (valid & ready): push the request PC into a PC-tag queue of depth DEPTH; outstanding+1; fetch_pc += 4, wrapping modulo 2^XLEN.
- On imem_resp_valid:
  - drop_cnt>0: discard the word, drop_cnt−1, outstanding−1, pop the tag.
  - Otherwise: write {tag PC, data} into the FIFO, outstanding−1, pop the tag.
- Output: out_valid = (fifo_count>0). out_pc and out_instr are driven from the head entry and stay stable while out_valid=1 and out_ready=0.
- Pop occurs on out_valid & out_ready. A push and a pop in the same cycle leave fifo_count unchanged. Pushing into a full FIFO cannot happen; it is covered by an assertion.
- Latency: an instruction becomes visible on out_* the cycle after its imem response, i.e. a registered push. There is no FIFO bypass.
- Redirect, in the cycle redirect_valid=1:
  - No request is issued.
  - FIFO is cleared, including any same-cycle push or pop.
  - fetch_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt = outstanding after this cycle's response accounting; any response in the redirect cycle itself is discarded.
  - The tag queue keeps its entries so stale responses still pop tags in order.
- Back-to-back redirects: the last one wins, and drop_cnt is recomputed each cycle.
- Reset mid-operation: reset takes priority over redirect and handshakes, and returns all state to reset values. Responses arriving after reset are the environment's responsibility; imem must be reset too.
- Counters: fifo_count and outstanding are each $clog2(DEPTH)+1 bits wide. The FIFO read/write pointers wrap modulo DEPTH.

Test Plan:
- Reset then steady flow: imem 1-cycle latency, out_ready=1 → out_pc sequence 0,4,8,C…, one instruction per cycle after the fill latency, words match the imem image.
- Backpressure: hold out_ready=0 for 10 cycles with DEPTH=4 → exactly 4 requests issued, imem_req_valid drops, head stays PC 0. On release, no gaps and no duplicates.
- Redirect with 2 responses in flight: redirect_pc=0x100 (latency 3) → the two stale words are dropped, and the next out_pc is 0x100, then 0x104.
- Redirect during a stall with a full FIFO: FIFO flushed, out_valid=0 the next cycle, then out_pc=0x40 for redirect_pc=0x42 (low bits cleared).
- Random imem_req_ready and variable response latency (1–4), 1000 instructions → out stream is strictly sequential between redirects, and (count + outstanding) ≤ DEPTH always.
- PC wrap: RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
